// File: rtl/serial_fxp_pkg.sv
// Shared definitions for the serial fixed-point divider and its operand loader.
//   state_t  : loader FSM encoding (LOAD_X, LOAD_Y, PRESENT)
//   WIDTH    : default operand width, shared with the divider
//   BEAT_W   : default input beat width
//   nbeats() : number of beats per operand
package serial_fxp_pkg;

    localparam int WIDTH  = 128;
    localparam int BEAT_W = 32;

    typedef enum logic [1:0] {
        LOAD_X  = 2'd0,
        LOAD_Y  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    function automatic int nbeats(input int w, input int b);
        return w / b;
    endfunction

endpackage

// File: rtl/beat_shift_reg.sv
// Assembles one operand from narrow beats, most-significant beat first.
// Ports:
//   clk    clock
//   i_rst  synchronous active-high reset (clears the register)
//   i_ld   shift enable: one accepted beat
//   i_din  incoming beat
//   o_q    assembled operand (held until the next load)
module beat_shift_reg #(
    parameter int width  = 128,
    parameter int beat_w = 32
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_ld,
    input  logic [beat_w-1:0] i_din,
    output logic [width-1:0]  o_q
);

    logic [width-1:0] r_q;
    logic [width-1:0] w_next;

    // A single-beat operand has nothing to shift, so the beat replaces it.
    generate
        if (width == beat_w) begin : g_one
            assign w_next = i_din;
        end else begin : g_shift
            assign w_next = {r_q[width-beat_w-1:0], i_din};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_rst)
            r_q <= '0;
        else if (i_ld)
            r_q <= w_next;
    end

    assign o_q = r_q;

endmodule

// File: rtl/serial_div_operand_loader.sv
// Operand loader feeding the serial fixed-point divider. Beats arrive on a
// single valid/ready channel: NBEATS beats of x, then NBEATS beats of y. The
// assembled pair is then offered on two independent valid/ready channels and
// no new beat is taken until both operands have been consumed.
// Optional feature (macro SERIAL_DIV_ZERO_CHK_EN): a pair whose divisor is
// zero is dropped on its last beat and div_zero_err pulses for one cycle.
// Ports:
//   clk, asyn_reset          clock; synchronous active-high reset
//   din, din_vld, din_rdy    beat input channel
//   x, data_x_vld/rdy        dividend channel to the divider
//   y, data_y_vld/rdy        divisor channel to the divider
//   div_zero_err             zero-divisor pulse (only with the macro)
module serial_div_operand_loader
    import serial_fxp_pkg::*;
#(
    parameter int width  = WIDTH,
    parameter int beat_w = BEAT_W
) (
    input  logic              clk,
    input  logic              asyn_reset,
    input  logic [beat_w-1:0] din,
    input  logic              din_vld,
    output logic              din_rdy,
    output logic [width-1:0]  x,
    output logic              data_x_vld,
    input  logic              data_x_rdy,
    output logic [width-1:0]  y,
    output logic              data_y_vld,
    input  logic              data_y_rdy
`ifdef SERIAL_DIV_ZERO_CHK_EN
    ,
    output logic              div_zero_err
`endif
);

    localparam int NBEATS = nbeats(width, beat_w);
    localparam int CNT_W  = $clog2(NBEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_x_vld, w_x_vld_nxt;
    logic             r_y_vld, w_y_vld_nxt;
    logic             w_ld_x, w_ld_y;
    logic             w_last;

    assign w_last = (r_cnt == LAST_BEAT);

`ifdef SERIAL_DIV_ZERO_CHK_EN
    logic r_dz, w_dz_nxt;
    logic w_y_next_zero;

    // Zero test on the value y is about to take, so the pair can be dropped
    // on the same edge that accepts its last beat.
    generate
        if (NBEATS == 1) begin : g_z_one
            assign w_y_next_zero = (din == '0);
        end else begin : g_z_shift
            assign w_y_next_zero = (y[width-beat_w-1:0] == '0) && (din == '0);
        end
    endgenerate
`endif

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            r_state <= LOAD_X;
            r_cnt   <= '0;
            r_x_vld <= 1'b0;
            r_y_vld <= 1'b0;
`ifdef SERIAL_DIV_ZERO_CHK_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x_vld <= w_x_vld_nxt;
            r_y_vld <= w_y_vld_nxt;
`ifdef SERIAL_DIV_ZERO_CHK_EN
            r_dz    <= w_dz_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_vld_nxt = r_x_vld;
        w_y_vld_nxt = r_y_vld;
        w_ld_x      = 1'b0;
        w_ld_y      = 1'b0;
`ifdef SERIAL_DIV_ZERO_CHK_EN
        w_dz_nxt    = 1'b0;
`endif
        case (r_state)
            LOAD_X: begin
                if (din_vld) begin
                    w_ld_x = 1'b1;
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = LOAD_Y;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            LOAD_Y: begin
                if (din_vld) begin
                    w_ld_y = 1'b1;
                    if (w_last) begin
                        w_cnt_nxt = '0;
`ifdef SERIAL_DIV_ZERO_CHK_EN
                        if (w_y_next_zero) begin
                            w_state_nxt = LOAD_X;
                            w_dz_nxt    = 1'b1;
                        end else begin
                            w_state_nxt = PRESENT;
                            w_x_vld_nxt = 1'b1;
                            w_y_vld_nxt = 1'b1;
                        end
`else
                        w_state_nxt = PRESENT;
                        w_x_vld_nxt = 1'b1;
                        w_y_vld_nxt = 1'b1;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            PRESENT: begin
                if (r_x_vld && data_x_rdy) w_x_vld_nxt = 1'b0;
                if (r_y_vld && data_y_rdy) w_y_vld_nxt = 1'b0;
                // Leave once neither operand is still pending after this edge.
                if (!w_x_vld_nxt && !w_y_vld_nxt) w_state_nxt = LOAD_X;
            end
            default: w_state_nxt = LOAD_X;
        endcase
    end

    beat_shift_reg #(.width(width), .beat_w(beat_w)) u_x_reg (
        .clk   (clk),
        .i_rst (asyn_reset),
        .i_ld  (w_ld_x),
        .i_din (din),
        .o_q   (x)
    );

    beat_shift_reg #(.width(width), .beat_w(beat_w)) u_y_reg (
        .clk   (clk),
        .i_rst (asyn_reset),
        .i_ld  (w_ld_y),
        .i_din (din),
        .o_q   (y)
    );

    // Beats are taken only while loading; the state alone decides this.
    assign din_rdy    = (r_state != PRESENT);
    assign data_x_vld = r_x_vld;
    assign data_y_vld = r_y_vld;
`ifdef SERIAL_DIV_ZERO_CHK_EN
    assign div_zero_err = r_dz;
`endif

endmodule

// File: tb/tb_serial_div_operand_loader.sv
module tb_serial_div_operand_loader;

    logic         clk = 1'b0;
    logic         asyn_reset;
    logic [31:0]  din;
    logic         din_vld, din_rdy;
    logic [127:0] x, y;
    logic         data_x_vld, data_x_rdy, data_y_vld, data_y_rdy;

    // Second instance: single-beat operands (beat_w == width).
    logic [127:0] d1_din;
    logic         d1_vld, d1_rdy;
    logic [127:0] d1_x, d1_y;
    logic         d1_xv, d1_xr, d1_yv, d1_yr;

`ifdef SERIAL_DIV_ZERO_CHK_EN
    logic         div_zero_err, d1_dz;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_div_operand_loader #(.width(128), .beat_w(32)) u_dut (
        .clk(clk), .asyn_reset(asyn_reset),
        .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
        .x(x), .data_x_vld(data_x_vld), .data_x_rdy(data_x_rdy),
        .y(y), .data_y_vld(data_y_vld), .data_y_rdy(data_y_rdy)
`ifdef SERIAL_DIV_ZERO_CHK_EN
        , .div_zero_err(div_zero_err)
`endif
    );

    serial_div_operand_loader #(.width(128), .beat_w(128)) u_dut1 (
        .clk(clk), .asyn_reset(asyn_reset),
        .din(d1_din), .din_vld(d1_vld), .din_rdy(d1_rdy),
        .x(d1_x), .data_x_vld(d1_xv), .data_x_rdy(d1_xr),
        .y(d1_y), .data_y_vld(d1_yv), .data_y_rdy(d1_yr)
`ifdef SERIAL_DIV_ZERO_CHK_EN
        , .div_zero_err(d1_dz)
`endif
    );

    typedef struct {
        logic [3:0][31:0] bx;   // bx[3] is sent first
        logic [3:0][31:0] by;
        logic [127:0]     ex;
        logic [127:0]     ey;
        int               xd;   // cycles after vld before data_x_rdy rises
        int               yd;
        bit               bub;  // random idle cycles between beats
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] b, input bit bub);
        bit acc;
        if (bub) begin
            for (int k = 0; k < 4 && $urandom_range(0, 1) == 1; k++) begin
                din_vld = 1'b0;
                tick();
            end
        end
        din     = b;
        din_vld = 1'b1;
        acc     = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = din_rdy;
            tick();
        end
        din_vld = 1'b0;
        check("beat_accept", {127'd0, acc}, 128'd1);
    endtask

    task automatic send_pair(input vec_t v);
        for (int i = 3; i >= 0; i--) send_beat(v.bx[i], v.bub);
        for (int i = 3; i >= 0; i--) send_beat(v.by[i], v.bub);
    endtask

    task automatic run_vec(input vec_t v);
        bit xdone, ydone, xh, yh;
        send_pair(v);
        check("present_x_vld", {127'd0, data_x_vld}, 128'd1);
        check("present_y_vld", {127'd0, data_y_vld}, 128'd1);
        check("present_din_rdy", {127'd0, din_rdy}, 128'd0);
        check("present_x", x, v.ex);
        check("present_y", y, v.ey);
        xdone = 1'b0;
        ydone = 1'b0;
        for (int c = 0; c < 40 && !(xdone && ydone); c++) begin
            data_x_rdy = (c >= v.xd);
            data_y_rdy = (c >= v.yd);
            check("x_stable", x, v.ex);
            check("y_stable", y, v.ey);
            check("x_vld_hold", {127'd0, data_x_vld}, {127'd0, !xdone});
            check("y_vld_hold", {127'd0, data_y_vld}, {127'd0, !ydone});
            xh = data_x_vld && data_x_rdy;
            yh = data_y_vld && data_y_rdy;
            tick();
            if (xh) xdone = 1'b1;
            if (yh) ydone = 1'b1;
            check("din_rdy_after_hs", {127'd0, din_rdy}, {127'd0, xdone && ydone});
        end
        data_x_rdy = 1'b0;
        data_y_rdy = 1'b0;
        check("pair_consumed", {127'd0, xdone && ydone}, 128'd1);
        check("x_vld_low", {127'd0, data_x_vld}, 128'd0);
        check("y_vld_low", {127'd0, data_y_vld}, 128'd0);
        check("x_held", x, v.ex);
        check("y_held", y, v.ey);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        tbl[0] = '{bx: {32'h0, 32'h0, 32'h0, 32'h64}, by: {32'h0, 32'h0, 32'h0, 32'h5},
                   ex: 128'd100, ey: 128'd5, xd: 0, yd: 0, bub: 1'b0};
        tbl[1] = '{bx: {32'h12345678, 32'h9abcdef0, 32'h0fedcba9, 32'h87654321},
                   by: {32'h0, 32'h0, 32'h1, 32'h0},
                   ex: 128'h12345678_9abcdef0_0fedcba9_87654321,
                   ey: 128'h00000000_00000000_00000001_00000000, xd: 3, yd: 7, bub: 1'b0};
        tbl[2] = '{bx: {32'h0, 32'h0, 32'h0, 32'h64}, by: {32'h0, 32'h0, 32'h0, 32'h5},
                   ex: 128'd100, ey: 128'd5, xd: 0, yd: 0, bub: 1'b1};
        tbl[3] = '{bx: {32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff},
                   by: {32'h80000000, 32'h0, 32'h0, 32'h1},
                   ex: {128{1'b1}}, ey: 128'h80000000_00000000_00000000_00000001,
                   xd: 5, yd: 2, bub: 1'b1};
        tbl[4] = '{bx: {32'hdeadbeef, 32'h0, 32'h0, 32'h1}, by: {32'h0, 32'hcafe, 32'h0, 32'h0},
                   ex: 128'hdeadbeef_00000000_00000000_00000001,
                   ey: 128'h00000000_0000cafe_00000000_00000000, xd: 2, yd: 2, bub: 1'b0};

        asyn_reset = 1'b1;
        din = '0; din_vld = 1'b0; data_x_rdy = 1'b0; data_y_rdy = 1'b0;
        d1_din = '0; d1_vld = 1'b0; d1_xr = 1'b1; d1_yr = 1'b1;
        tick();
        tick();
        check("rst_x", x, 128'd0);
        check("rst_y", y, 128'd0);
        check("rst_din_rdy", {127'd0, din_rdy}, 128'd1);
        check("rst_x_vld", {127'd0, data_x_vld}, 128'd0);
        check("rst_y_vld", {127'd0, data_y_vld}, 128'd0);
`ifdef SERIAL_DIV_ZERO_CHK_EN
        check("rst_dz", {127'd0, div_zero_err}, 128'd0);
`endif
        asyn_reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Reset after 4 x beats and 1 y beat, then a clean pair 7 / 3.
        for (int i = 0; i < 4; i++) send_beat(32'haaaaaaaa, 1'b0);
        send_beat(32'hffffffff, 1'b0);
        asyn_reset = 1'b1;
        tick();
        asyn_reset = 1'b0;
        check("midrst_x", x, 128'd0);
        check("midrst_y", y, 128'd0);
        check("midrst_din_rdy", {127'd0, din_rdy}, 128'd1);
        check("midrst_x_vld", {127'd0, data_x_vld}, 128'd0);
        check("midrst_y_vld", {127'd0, data_y_vld}, 128'd0);
        v = '{bx: {32'h0, 32'h0, 32'h0, 32'h7}, by: {32'h0, 32'h0, 32'h0, 32'h3},
              ex: 128'd7, ey: 128'd3, xd: 1, yd: 0, bub: 1'b0};
        run_vec(v);

`ifdef SERIAL_DIV_ZERO_CHK_EN
        v = '{bx: {32'h0, 32'h0, 32'h0, 32'h9}, by: {32'h0, 32'h0, 32'h0, 32'h0},
              ex: 128'd9, ey: 128'd0, xd: 0, yd: 0, bub: 1'b0};
        send_pair(v);
        check("dz_pulse", {127'd0, div_zero_err}, 128'd1);
        check("dz_x_vld", {127'd0, data_x_vld}, 128'd0);
        check("dz_y_vld", {127'd0, data_y_vld}, 128'd0);
        check("dz_din_rdy", {127'd0, din_rdy}, 128'd1);
        tick();
        check("dz_pulse_end", {127'd0, div_zero_err}, 128'd0);
        check("dz_x_vld2", {127'd0, data_x_vld}, 128'd0);
        v.by = {32'h0, 32'h0, 32'h0, 32'h3};
        v.ey = 128'd3;
        run_vec(v);
`endif

        // Single-beat operands: 12 then 4, consumer always ready.
        d1_din = 128'd12;
        d1_vld = 1'b1;
        tick();
        check("nb1_x_after1", d1_x, 128'd12);
        check("nb1_vld_after1", {127'd0, d1_xv}, 128'd0);
        check("nb1_rdy_after1", {127'd0, d1_rdy}, 128'd1);
        d1_din = 128'd4;
        tick();
        d1_vld = 1'b0;
        check("nb1_x", d1_x, 128'd12);
        check("nb1_y", d1_y, 128'd4);
        check("nb1_x_vld", {127'd0, d1_xv}, 128'd1);
        check("nb1_y_vld", {127'd0, d1_yv}, 128'd1);
        check("nb1_rdy_present", {127'd0, d1_rdy}, 128'd0);
        tick();
        check("nb1_x_vld_low", {127'd0, d1_xv}, 128'd0);
        check("nb1_y_vld_low", {127'd0, d1_yv}, 128'd0);
        check("nb1_rdy_back", {127'd0, d1_rdy}, 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
